// File: rtl/blake_round_ctrl.sv
// BLAKE-512 round sequencer: holds one header and strobes init, ROUNDS*4 steps and finalize.
// Latency: out_valid at accept + 3 + ROUNDS*4*G_LAT; out_valid holds until out_ready, and no new header is taken meanwhile.
module blake_round_ctrl #(
  parameter int ROUNDS = 16,
  parameter int G_LAT  = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [639:0] msg_in,
  output logic [639:0] msg_out,
  output logic [5:0]   counter_idx,
  output logic         v_init_en,
  output logic         step_en,
  output logic         fin_en,
  output logic         busy,
  output logic         out_valid,
  input  logic         out_ready
);

  localparam logic [5:0] LAST_IDX  = 6'(ROUNDS * 4 - 1);
  localparam logic [2:0] LAST_WAIT = 3'(G_LAT - 1);

  typedef enum logic [2:0] {IDLE, INIT, ROUND, FIN, OUT} state_t;

  state_t     state, state_nxt;
  logic [2:0] wait_cnt;
  logic       accept;
  logic       step_due;
  logic       last_step;

  assign accept    = (state == IDLE) && in_valid;
  assign step_due  = (state == ROUND) && (wait_cnt == LAST_WAIT);
  assign last_step = (counter_idx == LAST_IDX);

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Every output is a decode of the state register or the wait counter.
  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    v_init_en = 1'b0;
    step_en   = 1'b0;
    fin_en    = 1'b0;
    out_valid = 1'b0;
    busy      = 1'b1;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        busy     = 1'b0;
        if (in_valid) state_nxt = INIT;
      end
      INIT: begin
        v_init_en = 1'b1;
        state_nxt = ROUND;
      end
      ROUND: begin
        step_en = step_due;
        if (step_due && last_step) state_nxt = FIN;
      end
      FIN: begin
        fin_en    = 1'b1;
        state_nxt = OUT;
      end
      OUT: begin
        out_valid = 1'b1;
        if (out_ready) state_nxt = IDLE;
      end
      default: begin
        busy      = 1'b0;
        state_nxt = IDLE;
      end
    endcase
  end

  // Final step leaves counter_idx parked on the last index for the consumer.
  always_ff @(posedge clk) begin
    if (rst) begin
      msg_out     <= '0;
      counter_idx <= '0;
      wait_cnt    <= '0;
    end else if (accept) begin
      msg_out     <= msg_in;
      counter_idx <= '0;
      wait_cnt    <= '0;
    end else if (state == ROUND) begin
      if (step_due) begin
        wait_cnt <= '0;
        if (!last_step) counter_idx <= counter_idx + 6'd1;
      end else begin
        wait_cnt <= wait_cnt + 3'd1;
      end
    end else if ((state == OUT) && out_ready) begin
      counter_idx <= '0;
    end
  end

endmodule

// File: tb/tb_blake_round_ctrl.sv
// Bench for blake_round_ctrl: three instances (16x1, 16x3, 10x1); directed blocks, scoreboard monitor checks strobe timing.
module tb_blake_round_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst;
  logic         iv[3];
  logic [639:0] mi[3];
  logic         ordy[3];
  logic         ir[3];
  logic [639:0] mo[3];
  logic [5:0]   ci[3];
  logic         vi[3], se[3], fe[3], bz[3], ov[3];

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;
  int rr[3] = '{16, 16, 10};
  int gg[3] = '{1, 3, 1};

  typedef struct {
    int           inst;
    logic [639:0] msg;
    int           lat;
  } exp_t;
  exp_t sbq[$];
  exp_t e;

  blake_round_ctrl #(.ROUNDS(16), .G_LAT(1)) u0 (
    .clk(clk), .rst(rst), .in_valid(iv[0]), .in_ready(ir[0]), .msg_in(mi[0]),
    .msg_out(mo[0]), .counter_idx(ci[0]), .v_init_en(vi[0]), .step_en(se[0]),
    .fin_en(fe[0]), .busy(bz[0]), .out_valid(ov[0]), .out_ready(ordy[0]));
  blake_round_ctrl #(.ROUNDS(16), .G_LAT(3)) u1 (
    .clk(clk), .rst(rst), .in_valid(iv[1]), .in_ready(ir[1]), .msg_in(mi[1]),
    .msg_out(mo[1]), .counter_idx(ci[1]), .v_init_en(vi[1]), .step_en(se[1]),
    .fin_en(fe[1]), .busy(bz[1]), .out_valid(ov[1]), .out_ready(ordy[1]));
  blake_round_ctrl #(.ROUNDS(10), .G_LAT(1)) u2 (
    .clk(clk), .rst(rst), .in_valid(iv[2]), .in_ready(ir[2]), .msg_in(mi[2]),
    .msg_out(mo[2]), .counter_idx(ci[2]), .v_init_en(vi[2]), .step_en(se[2]),
    .fin_en(fe[2]), .busy(bz[2]), .out_valid(ov[2]), .out_ready(ordy[2]));

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic chk_msg(input string nm, input logic [639:0] act, input logic [639:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Monitor state per instance: block start cycle, strobe tallies, expected step index.
  bit           act[3], post[3], ovs[3];
  int           t0[3], ni[3], ns[3], nf[3], eidx[3];
  int           gi[3], gs[3], gf[3], go[3];
  logic [639:0] emsg[3];

  always @(negedge clk) begin
    for (int i = 0; i < 3; i++) begin
      if (rst) begin
        act[i]  = 1'b0;
        post[i] = 1'b0;
      end else begin
        if (vi[i]) gi[i]++;
        if (se[i]) gs[i]++;
        if (fe[i]) gf[i]++;
        if (ov[i]) go[i]++;
        if (vi[i] || se[i] || fe[i])
          chk("strobe_excl", 64'($countones({vi[i], se[i], fe[i]})), 64'd1);
        if (post[i]) begin
          chk("idle_after_out", {62'd0, ir[i], ov[i]}, 64'd2);
          post[i] = 1'b0;
        end
        if (!act[i]) begin
          if (vi[i] || se[i] || fe[i] || ov[i])
            chk("stray_strobe", {60'd0, vi[i], se[i], fe[i], ov[i]}, 64'd0);
        end else begin
          if (vi[i]) begin
            chk("init_cycle", 64'(cyc - t0[i]), 64'd1);
            ni[i]++;
          end else if (ni[i] == 1 && nf[i] == 0 && !fe[i]) begin
            chk("idx_hold", 64'(ci[i]), 64'(eidx[i]));
          end
          if (se[i]) begin
            chk("step_cycle", 64'(cyc - t0[i]), 64'(1 + gg[i] * (eidx[i] + 1)));
            eidx[i]++;
            ns[i]++;
          end
          if (fe[i]) begin
            chk("fin_cycle", 64'(cyc - t0[i]), 64'(2 + rr[i] * 4 * gg[i]));
            chk("steps_at_fin", 64'(ns[i]), 64'(rr[i] * 4));
            nf[i]++;
          end
          if (ov[i]) begin
            if (!ovs[i]) begin
              ovs[i] = 1'b1;
              if (sbq.size() == 0) begin
                chk("sb_nonempty", 64'd0, 64'd1);
              end else begin
                e = sbq.pop_front();
                chk("sb_inst", 64'(e.inst), 64'(i));
                chk("out_latency", 64'(cyc - t0[i]), 64'(e.lat));
                emsg[i] = e.msg;
              end
            end
            chk_msg("msg_out_hold", mo[i], emsg[i]);
            chk("idx_final", 64'(ci[i]), 64'(rr[i] * 4 - 1));
            chk("in_ready_low", 64'(ir[i]), 64'd0);
            if (ordy[i]) begin
              chk("init_count", 64'(ni[i]), 64'd1);
              chk("fin_count", 64'(nf[i]), 64'd1);
              act[i]  = 1'b0;
              post[i] = 1'b1;
            end
          end
        end
        if (iv[i] && ir[i]) begin
          act[i]  = 1'b1;
          t0[i]   = cyc;
          ni[i]   = 0;
          ns[i]   = 0;
          nf[i]   = 0;
          eidx[i] = 0;
          ovs[i]  = 1'b0;
        end
      end
    end
  end

  task automatic push_exp(input int i, input logic [639:0] m, input int lat);
    exp_t x;
    x.inst = i;
    x.msg  = m;
    x.lat  = lat;
    sbq.push_back(x);
  endtask

  // Leaves in_valid high; returns at posedge+1 after the accepting edge.
  task automatic present(input int i, input logic [639:0] m, output int t);
    int n;
    n     = 0;
    iv[i] = 1'b1;
    mi[i] = m;
    @(negedge clk);
    while (!ir[i] && n < 400) begin
      @(negedge clk);
      n++;
    end
    if (n >= 400) chk("accept_timeout", 64'd0, 64'd1);
    t = cyc;
    @(posedge clk); #1;
  endtask

  task automatic send(input int i, input logic [639:0] m, input int lat, input bit push);
    int t;
    if (push) push_exp(i, m, lat);
    present(i, m, t);
    iv[i] = 1'b0;
    @(negedge clk);
    chk_msg("capture", mo[i], m);
    @(posedge clk); #1;
  endtask

  task automatic wait_out(input int i, input bit need_rdy, input int lim);
    int n;
    n = 0;
    @(negedge clk);
    while (!(ov[i] && (ordy[i] || !need_rdy)) && n < lim) begin
      @(negedge clk);
      n++;
    end
    if (n >= lim) chk("out_timeout", 64'd0, 64'd1);
    @(posedge clk); #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int n, ta, tb, s_i, s_s, s_f, s_fin, s_out;
    logic [639:0] pat_a, pat_b;
    pat_a = {80{8'hA5}};
    pat_b = {80{8'h5A}};
    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      iv[i]   = 1'b0;
      mi[i]   = '0;
      ordy[i] = 1'b1;
      gi[i] = 0; gs[i] = 0; gf[i] = 0; go[i] = 0;
    end
    repeat (3) @(posedge clk);
    @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      chk("rst_flags", {58'd0, vi[i], se[i], fe[i], bz[i], ov[i], ir[i]}, 64'd1);
      chk("rst_idx", 64'(ci[i]), 64'd0);
      chk_msg("rst_msg", mo[i], '0);
    end
    @(posedge clk); #1;
    rst = 1'b0;

    // Single block, out_ready tied high.
    send(0, {10{64'h0123456789abcdef}}, 67, 1'b1);
    wait_out(0, 1'b1, 200);

    // Backpressure: out_ready low for 10 cycles, all-ones header waits behind it.
    ordy[0] = 1'b0;
    send(0, {10{64'hfedcba9876543210}}, 67, 1'b1);
    wait_out(0, 1'b0, 200);
    fork
      send(0, {640{1'b1}}, 67, 1'b1);
      begin
        repeat (9) begin @(posedge clk); #1; end
        ordy[0] = 1'b1;
      end
    join
    wait_out(0, 1'b1, 200);

    // Reset in the middle of a block at counter_idx 21.
    send(0, {10{64'h1122334455667788}}, 0, 1'b0);
    n = 0;
    while (ci[0] != 6'd21 && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    chk("reach_idx21", 64'(ci[0]), 64'd21);
    s_fin = gf[0];
    s_out = go[0];
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("midrst_flags", {58'd0, vi[0], se[0], fe[0], bz[0], ov[0], ir[0]}, 64'd1);
    chk("midrst_idx", 64'(ci[0]), 64'd0);
    chk_msg("midrst_msg", mo[0], '0);
    @(posedge clk); #1;
    rst = 1'b0;
    repeat (80) begin @(posedge clk); #1; end
    chk("abort_no_fin", 64'(gf[0] - s_fin), 64'd0);
    chk("abort_no_out", 64'(go[0] - s_out), 64'd0);
    send(0, {10{64'h99aabbccddeeff00}}, 67, 1'b1);
    wait_out(0, 1'b1, 200);

    // Back-to-back blocks with in_valid held high.
    s_i = gi[0];
    s_s = gs[0];
    s_f = gf[0];
    push_exp(0, pat_a, 67);
    push_exp(0, pat_b, 67);
    present(0, pat_a, ta);
    present(0, pat_b, tb);
    iv[0] = 1'b0;
    chk("b2b_gap", 64'(tb - ta), 64'd68);
    @(negedge clk);
    chk_msg("b2b_msg_b", mo[0], pat_b);
    @(posedge clk); #1;
    wait_out(0, 1'b1, 200);
    chk("b2b_inits", 64'(gi[0] - s_i), 64'd2);
    chk("b2b_steps", 64'(gs[0] - s_s), 64'd128);
    chk("b2b_fins", 64'(gf[0] - s_f), 64'd2);

    // G_LAT=3 and ROUNDS=10 instances.
    send(1, {10{64'h0f1e2d3c4b5a6978}}, 195, 1'b1);
    wait_out(1, 1'b1, 400);
    send(2, {10{64'h8796a5b4c3d2e1f0}}, 43, 1'b1);
    wait_out(2, 1'b1, 200);

    repeat (3) begin @(posedge clk); #1; end
    chk("sb_drained", 64'(sbq.size()), 64'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/blake_round_ctrl.md
Name: blake_round_ctrl

Overview:
- Sequencer for the dual-G BLAKE-512 compression datapath: accepts one 640-bit header, holds it stable for the message/constant mux, and steps the mux's 6-bit counter_idx through ROUNDS×4 steps.
- Two G functions execute per step; one round is 4 steps.
- Emits load, step and finalize strobes for the state register file.
- Handles the result handshake toward the downstream consumer.

Parameters:
- ROUNDS, 16, number of BLAKE-512 rounds; legal range 1..16 (counter_idx is 6 bits).
- G_LAT, 1, cycles counter_idx is held per step (G pipeline depth); legal range 1..8.

Ports:
- clk  input  1  system clock, all logic on the rising edge.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  header available on msg_in.
- in_ready  output  1  controller can accept a header.
- msg_in  input  640  header word stream, word0 in [639:576].
- msg_out  output  640  registered header feeding the message mux; stable from INIT through OUT.
- counter_idx  output  6  {round[3:0], step[1:0]} to the message mux.
- v_init_en  output  1  one-cycle strobe: load v[0..15] from chain value, salt, counter and constants.
- step_en  output  1  G outputs for the current counter_idx are written back to v this cycle.
- fin_en  output  1  one-cycle strobe: h' = h ^ s ^ v[i] ^ v[i+8].
- busy  output  1  high in every state except IDLE.
- out_valid  output  1  digest valid in the state register file.
- out_ready  input  1  consumer accepts the digest.

Behaviour:
- States: IDLE, INIT, ROUND, FIN, OUT. Reset value is IDLE.
- Output reset values:
  - msg_out = 0, counter_idx = 0, wait_cnt = 0.
  - All strobes, busy and out_valid = 0.
  - in_ready = 1 from the first cycle after reset.
- All outputs are registered or decoded from state only. There is no combinational path from inputs to outputs.
- IDLE:
  - in_ready = 1.
  - On in_valid & in_ready: capture msg_in into msg_out, clear counter_idx and wait_cnt, go to INIT.
  - in_ready is 0 in all other states. in_valid outside IDLE is ignored.
- INIT: v_init_en = 1 for exactly one cycle, then go to ROUND.
- ROUND:
  - counter_idx is held for G_LAT cycles while wait_cnt counts 0..G_LAT-1.
  - step_en = 1 only when wait_cnt == G_LAT-1; wait_cnt then returns to 0.
  - On the same edge counter_idx increments by 1. step is bits [1:0], round is bits [5:2], and the carry from step 3 to the next round is natural binary.
  - When step_en is high and counter_idx == ROUNDS*4-1: go to FIN. counter_idx does not increment; it holds ROUNDS*4-1.
- FIN: fin_en = 1 for one cycle, then go to OUT.
- OUT:
  - out_valid = 1 and held until out_ready is sampled high.
  - On out_valid & out_ready: go to IDLE and reset counter_idx to 0. in_ready is 1 on the next cycle.
  - out_ready while out_valid = 0 has no effect.
- Latency: handshake edge T → out_valid first high at T + 3 + ROUNDS*4*G_LAT cycles. Default: T+67.
  - v_init_en is high during cycle T+1.
  - The first step_en is at T+1+G_LAT.
  - fin_en is at T+2+ROUNDS*4*G_LAT.
- Strobe counts per block: exactly one v_init_en, ROUNDS*4 step_en, one fin_en.
- step_en, v_init_en and fin_en are mutually exclusive.
- msg_out changes only on an accepted IDLE handshake.
- rst asserted in any state:
  - Next cycle, all state and outputs return to reset values.
  - In-flight strobes are dropped; no fin_en or out_valid is produced for the aborted block.
- No throughput overlap: the next header is accepted no earlier than one cycle after the out handshake.

Test Plan:
- Reset then single block, G_LAT=1, ROUNDS=16, out_ready tied 1, handshake at T:
  - v_init_en at T+1.
  - step_en at T+2..T+65 with counter_idx = 0..63 in order.
  - fin_en at T+66, out_valid at T+67 for 1 cycle, in_ready high at T+68.
- G_LAT=3:
  - Each counter_idx value is held 3 cycles with step_en only in the third.
  - counter_idx 3→4 rollover is exactly at a step_en edge.
  - out_valid at T+3+192 = T+195.
- Backpressure: out_ready low for 10 cycles after out_valid.
  - out_valid, msg_out and counter_idx = 63 stay stable; in_ready stays 0.
  - A new in_valid with msg_in = all-ones is ignored until release.
  - After release, the next header is captured.
- Mid-operation reset: assert rst when counter_idx = 21.
  - Next cycle: state IDLE, counter_idx = 0, msg_out = 0, no fin_en or out_valid.
  - A fresh block then completes with normal latency.
- Back-to-back blocks with in_valid held high: second capture occurs in the cycle after the first out handshake.
  - msg_out updates from pattern A (0xA5 repeated) to B (0x5A repeated) only at that edge.
  - Total strobe counts are 2 / 128 / 2.
- ROUNDS=10: last step_en is at counter_idx = 39, fin_en follows, and out_valid is at T+43.
